// File: rtl/imem_fetch_responder_if.sv
// Fetch-side bundle between the IF stage (master) and the instruction-memory responder (slave).
interface imem_fetch_responder_if #(
   parameter int WORD_BITWIDTH = 32,
   parameter int DEPTH_LOG2    = 10
);
   logic [WORD_BITWIDTH-1:0] pc;
   logic                     flush;
   logic                     id_stall;
   logic                     stall_out;
   logic [WORD_BITWIDTH-1:0] instr;
   logic [WORD_BITWIDTH-1:0] instr_pc;
   logic                     instr_valid;
   logic                     wr_en;
   logic [DEPTH_LOG2-1:0]    wr_addr;
   logic [WORD_BITWIDTH-1:0] wr_data;
`ifdef IMEM_FAULT_EN
   logic                     instr_fault;
`endif

   modport master (
      output pc, flush, id_stall, wr_en, wr_addr, wr_data,
      input  stall_out, instr, instr_pc, instr_valid
`ifdef IMEM_FAULT_EN
      , input instr_fault
`endif
   );

   modport slave (
      input  pc, flush, id_stall, wr_en, wr_addr, wr_data,
      output stall_out, instr, instr_pc, instr_valid
`ifdef IMEM_FAULT_EN
      , output instr_fault
`endif
   );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: returns the RAM word for the IF pc WAIT_STATES+1 edges after accept,
// holding IF via stall_out while busy or while ID back-pressures; flush drops the fetch. IMEM_FAULT_EN adds instr_fault.
module imem_fetch_responder #(
   parameter int                       WORD_BITWIDTH = 32,
   parameter int                       DEPTH_LOG2    = 10,
   parameter int                       WAIT_STATES   = 2,
   parameter logic [WORD_BITWIDTH-1:0] NOP_INSN      = 32'h00000013
) (
   input  logic                  clk,
   input  logic                  rst,
   imem_fetch_responder_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_e;

   localparam int                       DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [3:0]               WAIT_CNT = 4'(WAIT_STATES);
   // IF parks its pc here while in reset; it never denotes a real fetch.
   localparam logic [WORD_BITWIDTH-1:0] SENTINEL = {{(WORD_BITWIDTH-2){1'b1}}, 2'b00};

   logic [WORD_BITWIDTH-1:0] mem_q [DEPTH];

   state_e                   state_q, state_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [WORD_BITWIDTH-1:0] req_pc_q, req_pc_d;
   logic [WORD_BITWIDTH-1:0] instr_q, instr_d;
   logic [WORD_BITWIDTH-1:0] instr_pc_q, instr_pc_d;
   logic                     valid_q, valid_d;
`ifdef IMEM_FAULT_EN
   logic                     fault_q, fault_d;
   logic                     fetch_fault;
`endif

   logic [DEPTH_LOG2-1:0]    rd_idx;
   logic                     out_of_range;
   logic [WORD_BITWIDTH-1:0] fetch_word;
   logic                     hold_id;
   logic                     deliver;

   always_ff @(posedge clk) begin
      if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
   end

   // Asynchronous read of the pre-edge contents gives old data on a same-edge write.
   assign rd_idx       = req_pc_q[DEPTH_LOG2+1:2];
   assign out_of_range = |req_pc_q[WORD_BITWIDTH-1:DEPTH_LOG2+2];

`ifdef IMEM_FAULT_EN
   assign fetch_fault = out_of_range || (req_pc_q[1:0] != 2'b00);
   assign fetch_word  = fetch_fault ? NOP_INSN : mem_q[rd_idx];
`else
   assign fetch_word  = out_of_range ? NOP_INSN : mem_q[rd_idx];
`endif

   assign hold_id = valid_q && bus.id_stall;
   assign deliver = (state_q == BUSY) && (cnt_q == 4'd0) && !hold_id;

   assign bus.stall_out = !bus.flush && (state_q == BUSY) && ((cnt_q != 4'd0) || hold_id);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_pc_d   = req_pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
`ifdef IMEM_FAULT_EN
      fault_d    = fault_q;
`endif
      if (bus.flush) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
         valid_d = 1'b0;
`ifdef IMEM_FAULT_EN
         fault_d = 1'b0;
`endif
      end else begin
         // ID takes the current word; a delivery below overrides this.
         if (valid_q && !bus.id_stall) valid_d = 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.pc != SENTINEL) begin
                  req_pc_d = bus.pc;
                  cnt_d    = WAIT_CNT;
                  state_d  = BUSY;
               end
            end
            BUSY: begin
               if (cnt_q != 4'd0) begin
                  cnt_d = cnt_q - 4'd1;
               end else if (deliver) begin
                  instr_d    = fetch_word;
                  instr_pc_d = req_pc_q;
                  valid_d    = 1'b1;
                  req_pc_d   = bus.pc;
                  cnt_d      = WAIT_CNT;
`ifdef IMEM_FAULT_EN
                  fault_d    = fetch_fault;
`endif
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         req_pc_q   <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
`ifdef IMEM_FAULT_EN
         fault_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_pc_q   <= req_pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
`ifdef IMEM_FAULT_EN
         fault_q    <= fault_d;
`endif
      end
   end

   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = valid_q;
`ifdef IMEM_FAULT_EN
   assign bus.instr_fault = fault_q;
`endif
endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Instruction-memory responder on the fetch side of the pipeline. It is the other end of the IF stage's pc interface. It latches the pc driven by IF and returns the instruction word from a word-addressed RAM after a configurable number of wait states. It drives the IF hold request (hz_PCWrite polarity: 1 = hold pc) while a fetch is in flight or ID is back-pressuring, and it drops wrong-path fetches on a branch redirect (PCSrc).

Parameters:
WORD_BITWIDTH, 32, instruction/pc width
DEPTH_LOG2, 10, log2 of RAM depth in words
WAIT_STATES, 2, extra cycles per fetch (0..15); throughput is 1 instr per WAIT_STATES+1 cycles
NOP_INSN, 32'h00000013, word returned for out-of-range fetches

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
pc  input  WORD_BITWIDTH  fetch address from IF
flush  input  1  branch redirect (same signal as IF PCSrc)
id_stall  input  1  ID not accepting the current instr this cycle
stall_out  output  1  to IF hz_PCWrite; 1 = hold pc
instr  output  WORD_BITWIDTH  fetched instruction
instr_pc  output  WORD_BITWIDTH  address of instr
instr_valid  output  1  instr/instr_pc valid
wr_en  input  1  RAM load strobe
wr_addr  input  DEPTH_LOG2  RAM word index
wr_data  input  WORD_BITWIDTH  RAM load data

Behaviour:
- Reset (async): state=IDLE, cnt=0, req_pc=0, instr=0, instr_pc=0, instr_valid=0. stall_out is combinational and reads 0 in reset.
- Word index is pc[DEPTH_LOG2+1:2]. Out of range means pc[WORD_BITWIDTH-1:DEPTH_LOG2+2] != 0; such fetches return NOP_INSN. pc[1:0] is ignored.
- RAM write happens on an edge when wr_en=1. A same-edge read of the same word returns the old data.
- States are IDLE (nothing in flight) and BUSY (request req_pc in flight, cnt = remaining wait cycles).
- IDLE:
  - stall_out=0.
  - At the edge, if pc != 32'hFFFFFFFC: req_pc<=pc, cnt<=WAIT_STATES, go BUSY.
  - pc == 32'hFFFFFFFC is the IF reset sentinel and is ignored; stay IDLE.
- BUSY, cnt!=0: stall_out=1, and cnt decrements at each edge.
- BUSY, cnt==0: deliver = !(instr_valid && id_stall).
  - If deliver: stall_out=0. At the edge: instr<=mem/NOP for req_pc, instr_pc<=req_pc, instr_valid<=1, req_pc<=pc, cnt<=WAIT_STATES. Stay BUSY (back-to-back fetch).
  - If not deliver: stall_out=1 and all outputs are held.
- Consumption: at an edge with instr_valid=1, id_stall=0 and no delivery, instr_valid<=0.
- Latency: WAIT_STATES+1 edges from accept to instr_valid. With WAIT_STATES=0: one instruction per cycle, stall_out=0 unless id_stall holds.
- flush has priority over everything, including id_stall:
  - stall_out is forced 0 while flush=1, so the IF takes branch_pc.
  - At the edge: instr_valid<=0, in-flight request discarded, state<=IDLE.
  - The branch target is accepted at the following edge.
- Reset mid-fetch aborts immediately to reset values.
- flush with wr_en: the write still occurs.

Optional Feature:
IMEM_FAULT_EN
- Defined: adds output instr_fault (1 bit, reset 0), updated together with instr on delivery.
  - instr_fault=1 when req_pc[1:0]!=0 or req_pc is out of range; instr is then NOP_INSN.
  - instr_fault clears along with instr_valid on flush.
- Undefined: the port is absent, pc[1:0] is ignored, and out-of-range fetches return NOP_INSN silently.

Test Plan:
- Load mem[0..3]=11,22,33,44 (hex words), WAIT_STATES=0, release reset with IF pc at FFFFFFFC -> no delivery for the sentinel. instr_pc/instr = 0/11, 4/22, 8/33 on consecutive cycles; stall_out never 1.
- WAIT_STATES=2, same image -> stall_out=1 for 2 cycles per fetch. instr_valid pulses every 3 cycles with pc 0,4,8, and pc is held during stall.
- WAIT_STATES=2, assert flush during cnt=1 with branch_pc=0x8 -> stall_out=0 that cycle, the in-flight pc 4 is never delivered. Next valid is instr_pc=8, instr=33, after 3 edges.
- WAIT_STATES=0, id_stall=1 for 3 cycles while instr_valid=1 (pc 4) -> instr is held at 22 and stall_out=1 for 3 cycles. pc 8 is delivered on the cycle after id_stall drops.
- pc=0x00001000 with DEPTH_LOG2=10 -> instr=00000013. With IMEM_FAULT_EN, instr_fault=1; pc=0x2 also gives instr_fault=1.
- wr_en writes mem[1]=AA on the same edge that pc 4 is delivered -> that delivery shows 22; a refetch of pc 4 after flush shows AA.
